// File: rtl/keccak_pkg.sv
// Shared constants, lane type and index helpers for the Keccak theta D stage.
package keccak_pkg;

  localparam int NUM_LANES      = 5;
  localparam int LANE_W_DEFAULT = 64;

  typedef logic [LANE_W_DEFAULT-1:0] lane_t;

  // Rotate left by one: the MSB wraps into bit 0.
  function automatic lane_t rol1(input lane_t v);
    return {v[LANE_W_DEFAULT-2:0], v[LANE_W_DEFAULT-1]};
  endfunction

  function automatic int prev5(input int x);
    return (x + NUM_LANES - 1) % NUM_LANES;
  endfunction

  function automatic int next5(input int x);
    return (x + 1) % NUM_LANES;
  endfunction

endpackage

// File: rtl/keccak_d_lane.sv
// Combinational D for one lane: D = cPrev ^ ROL(cNext, 1).
module keccak_d_lane #(
  parameter int LANE_W = 64
) (
  input  logic [LANE_W-1:0] cPrev_i,
  input  logic [LANE_W-1:0] cNext_i,
  output logic [LANE_W-1:0] dLane_o
);

  assign dLane_o = cPrev_i ^ {cNext_i[LANE_W-2:0], cNext_i[LANE_W-1]};

endmodule

// File: rtl/keccak_theta_d.sv
// Keccak theta "D" stage, one registered cycle with valid qualifier.
// Optional XOR-reduced parity output enabled by KECCAK_THETA_D_PARITY_EN.
module keccak_theta_d
  import keccak_pkg::*;
#(
  parameter int LANE_W = LANE_W_DEFAULT
) (
  input  logic                          inClk,
  input  logic                          inRst,
  input  logic                          inValid,
  input  logic [NUM_LANES*LANE_W-1:0]   inData,
`ifdef KECCAK_THETA_D_PARITY_EN
  output logic                          outParity,
`endif
  output logic                          outValid,
  output logic [NUM_LANES*LANE_W-1:0]   outData
);

  logic [NUM_LANES*LANE_W-1:0] dComb;
  logic [NUM_LANES*LANE_W-1:0] data_d, data_q;
  logic                        valid_d, valid_q;

  // Lane x pulls C from its neighbours, wrapping around the five lanes.
  for (genvar x = 0; x < NUM_LANES; x++) begin : gLane
    localparam int P = prev5(x);
    localparam int N = next5(x);
    keccak_d_lane #(.LANE_W(LANE_W)) uLane (
      .cPrev_i (inData[LANE_W*P +: LANE_W]),
      .cNext_i (inData[LANE_W*N +: LANE_W]),
      .dLane_o (dComb[LANE_W*x +: LANE_W])
    );
  end

  // Valid comes only from inValid, so unknown data on idle cycles cannot reach it.
  always_comb begin
    valid_d = inValid;
    data_d  = data_q;
    if (inValid) data_d = dComb;
  end

  always_ff @(posedge inClk) begin
    if (inRst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign outValid = valid_q;
  assign outData  = data_q;

`ifdef KECCAK_THETA_D_PARITY_EN
  logic parity_d, parity_q;

  always_comb begin
    parity_d = parity_q;
    if (inValid) parity_d = ^dComb;
  end

  always_ff @(posedge inClk) begin
    if (inRst) parity_q <= 1'b0;
    else       parity_q <= parity_d;
  end

  assign outParity = parity_q;
`endif

endmodule

// File: tb/tb_keccak_theta_d.sv
// Scoreboard bench for keccak_theta_d at LANE_W=64 and LANE_W=8 (parity checked when KECCAK_THETA_D_PARITY_EN is defined).
module tb_keccak_theta_d;

  logic         inClk = 1'b0;
  logic         inRst;
  logic         inValid;
  logic [319:0] inData;
  logic [39:0]  inData8;
  logic         outValid, outValid8;
  logic [319:0] outData;
  logic [39:0]  outData8;
`ifdef KECCAK_THETA_D_PARITY_EN
  logic         outParity, outParity8;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic         v;
    logic [319:0] d;
    logic [39:0]  d8;
    logic         p;
  } exp_t;

  exp_t sb[$];
  logic [319:0] heldD;
  logic [39:0]  heldD8;
  logic         heldP;

  keccak_theta_d #(.LANE_W(64)) dut (
    .inClk(inClk), .inRst(inRst), .inValid(inValid), .inData(inData),
`ifdef KECCAK_THETA_D_PARITY_EN
    .outParity(outParity),
`endif
    .outValid(outValid), .outData(outData)
  );

  keccak_theta_d #(.LANE_W(8)) dut8 (
    .inClk(inClk), .inRst(inRst), .inValid(inValid), .inData(inData8),
`ifdef KECCAK_THETA_D_PARITY_EN
    .outParity(outParity8),
`endif
    .outValid(outValid8), .outData(outData8)
  );

  always #5 inClk = ~inClk;

  // Reference: lanes extracted with shifts/masks, rotation done arithmetically.
  function automatic logic [319:0] computeD(input logic [319:0] c, input int w);
    logic [319:0] one, mask, res, rot;
    logic [319:0] lane [5];
    one  = 320'd1;
    mask = (one << w) - one;
    for (int i = 0; i < 5; i++) lane[i] = (c >> (w * i)) & mask;
    res = '0;
    for (int x = 0; x < 5; x++) begin
      rot = ((lane[(x + 1) % 5] << 1) | (lane[(x + 1) % 5] >> (w - 1))) & mask;
      res = res | (((lane[(x + 4) % 5] ^ rot) & mask) << (w * x));
    end
    return res;
  endfunction

  function automatic logic [319:0] rand320();
    logic [319:0] r;
    for (int i = 0; i < 10; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic applyStimulus(input logic rst, input logic valid,
                               input logic [319:0] d, input logic [39:0] d8);
    exp_t e;
    logic [319:0] full8;
    @(negedge inClk);
    inRst   = rst;
    inValid = valid;
    inData  = valid ? d : 'x;
    inData8 = valid ? d8 : 'x;
    if (rst) begin
      heldD = '0; heldD8 = '0; heldP = 1'b0;
      e.v = 1'b0;
    end else if (valid) begin
      heldD  = computeD(d, 64);
      full8  = computeD({280'd0, d8}, 8);
      heldD8 = full8[39:0];
      heldP  = ^heldD;
      e.v = 1'b1;
    end else begin
      e.v = 1'b0;
    end
    e.d = heldD; e.d8 = heldD8; e.p = heldP;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    checks++;
    if (outValid !== e.v) begin
      errors++;
      $display("[TB] FAIL valid64: got %b want %b", outValid, e.v);
    end
    checks++;
    if (outData !== e.d) begin
      errors++;
      $display("[TB] FAIL data64: got %h want %h", outData, e.d);
    end
    checks++;
    if (outValid8 !== e.v) begin
      errors++;
      $display("[TB] FAIL valid8: got %b want %b", outValid8, e.v);
    end
    checks++;
    if (outData8 !== e.d8) begin
      errors++;
      $display("[TB] FAIL data8: got %h want %h", outData8, e.d8);
    end
`ifdef KECCAK_THETA_D_PARITY_EN
    checks++;
    if (outParity !== e.p) begin
      errors++;
      $display("[TB] FAIL parity64: got %b want %b", outParity, e.p);
    end
`endif
  endtask

  // Monitor: after each rising edge, pop the entry queued for that edge.
  initial begin
    forever begin
      @(posedge inClk);
      #1;
      if (sb.size() > 0) checkOutput(sb.pop_front());
    end
  end

  logic [319:0] vSpec, vOnes, vC1, vZero;
  logic [39:0]  v8;

  initial begin
    inRst = 1'b1; inValid = 1'b0; inData = '0; inData8 = '0;
    heldD = '0; heldD8 = '0; heldP = 1'b0;

    vSpec = '0;
    vSpec[63:0]    = 64'h00000001997b5853;
    vSpec[255:192] = 64'h8000000000000000;
    vOnes = '0;
    vOnes[63:0] = '1;
    vC1 = '0;
    vC1[127:64] = 64'h8000000000000000;
    vZero = '0;
    v8 = 40'h0080000000;

    // Reset with valid asserted
    applyStimulus(1'b1, 1'b1, rand320(), 40'h1234567890);
    applyStimulus(1'b1, 1'b1, rand320(), 40'h0badc0ffee);
    // Known vectors, back to back, then idle with held data
    applyStimulus(1'b0, 1'b1, vSpec, v8);
    applyStimulus(1'b0, 1'b1, vOnes, 40'hff);
    applyStimulus(1'b0, 1'b1, vC1, 40'h8000);
    applyStimulus(1'b0, 1'b1, vSpec, v8);
    applyStimulus(1'b0, 1'b1, vOnes, 40'hff);
    applyStimulus(1'b0, 1'b1, vZero, 40'h0);
    applyStimulus(1'b0, 1'b0, vZero, 40'h0);
    applyStimulus(1'b0, 1'b1, vSpec, v8);
    applyStimulus(1'b0, 1'b0, vZero, 40'h0);
    applyStimulus(1'b0, 1'b0, vZero, 40'h0);
    // Reset mid-stream, then restart
    applyStimulus(1'b0, 1'b1, vOnes, 40'hff);
    applyStimulus(1'b1, 1'b1, vSpec, v8);
    applyStimulus(1'b0, 1'b1, vC1, 40'h8000);
    applyStimulus(1'b0, 1'b0, vZero, 40'h0);
    // Randomized traffic with occasional resets
    for (int i = 0; i < 300; i++) begin
      applyStimulus(($urandom_range(0, 31) == 0), ($urandom_range(0, 9) < 7),
                    rand320(), {$urandom, 8'($urandom)});
    end
    applyStimulus(1'b0, 1'b0, vZero, 40'h0);

    repeat (3) @(posedge inClk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
